// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and
// default parameter values used by the core integration.
package pipe_stall_ctrl_pkg;

  // Memory-access sequencer states
  typedef enum logic {
    PSC_IDLE = 1'b0,
    PSC_WAIT = 1'b1
  } psc_state_e;

  // Default register address width of the core
  localparam int PSC_ASIZE   = 5;
  // Default number of cycles to wait for dmem_ready before giving up
  localparam int PSC_TIMEOUT = 64;
  // Default width of the stall performance counter
  localparam int PSC_CNT_W   = 16;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard detector. Purely combinational so it can be shared with
// the forwarding unit: flags an ID instruction that needs a value still
// being loaded by the instruction in EX.
module pipe_stall_ctrl_hazard_detect
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int ASIZE = PSC_ASIZE
) (
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_wen,
  input  logic [ASIZE-1:0] ex_waddr,
  output logic             load_use
);

  logic ex_load_dst;
  logic rs_match;
  logic rt_match;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard
  always_comb begin
    ex_load_dst = ex_mem_read & ex_wen & (ex_waddr != '0);
    rs_match    = (ex_waddr == id_rs);
    rt_match    = id_uses_rt & (ex_waddr == id_rt);
    load_use    = ex_load_dst & (rs_match | rt_match);
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer for the 5-stage core. Produces stage-register
// enables and flushes for load-use stalls, EX redirects and multi-cycle
// data-memory accesses, with a watchdog that releases a hung access and
// records a sticky error. Also counts cycles in which the PC was held.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int ASIZE   = PSC_ASIZE,
  parameter int TIMEOUT = PSC_TIMEOUT,
  parameter int CNT_W   = PSC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_wen,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_redirect,
  input  logic             mem_read_m,
  input  logic             mem_write_m,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wide enough to hold the value TIMEOUT itself
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  psc_state_e        state_q;
  psc_state_e        state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [WCNT_W-1:0] wait_cnt_d;
  logic              mem_op;
  logic              mem_stall;
  logic              req_c;
  logic              err_set;
  logic              load_use;

  // Counter increment that holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pipe_stall_ctrl_hazard_detect #(
    .ASIZE (ASIZE)
  ) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_wen      (ex_wen),
    .ex_waddr    (ex_waddr),
    .load_use    (load_use)
  );

  assign mem_op = mem_read_m | mem_write_m;

  // Memory sequencer next-state: detect a slow access, wait for ready or timeout
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    req_c      = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      PSC_IDLE: begin
        req_c = mem_op;
        if (mem_op && !dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = PSC_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      PSC_WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) begin
          state_d    = PSC_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= WCNT_W'(TIMEOUT)) begin
          // Give up on the access: release the pipeline as if it completed
          err_set    = 1'b1;
          state_d    = PSC_IDLE;
          wait_cnt_d = '0;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d    = PSC_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stage controls: memory stall outranks redirect, which outranks load-use
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_req     = req_c;
    if (!rst_n) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      dmem_req  = 1'b0;
    end else if (mem_stall) begin
      // Freeze everything; MEM/WB gets a bubble since the access has no result yet
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      // The ID instruction is wrong-path, so any load-use it causes is moot
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // FSM state and watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PSC_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Sticky watchdog error, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else if (err_set) begin
      mem_err <= 1'b1;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_en) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the sequencing rules.
module tb_pipe_stall_ctrl;

  localparam int ASIZE = 5;
  localparam int TMO   = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ASIZE-1:0] id_rs = '0, id_rt = '0, ex_waddr = '0;
  logic id_uses_rt = 0, ex_mem_read = 0, ex_wen = 0, ex_redirect = 0;
  logic mem_read_m = 0, mem_write_m = 0, dmem_ready = 0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, dmem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad = 0;

  // model state: cycles the current access has been outstanding (0 = none)
  int m_waited = 0;
  logic m_err = 0;
  logic [CNT_W-1:0] m_cnt = '0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.ASIZE(ASIZE), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_redirect(ex_redirect), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .dmem_req(dmem_req),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  function automatic logic m_load_use();
    return ex_mem_read && ex_wen && (ex_waddr != 0) &&
           ((ex_waddr == id_rs) || (id_uses_rt && ex_waddr == id_rt));
  endfunction

  // memory holds the pipeline while an access is unfinished and not yet timed out
  function automatic logic m_mem_stall();
    if (dmem_ready) return 1'b0;
    if (m_waited > 0) return (m_waited < TMO);
    return mem_read_m || mem_write_m;
  endfunction

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl, req}
  function automatic logic [8:0] exp_vec();
    logic req;
    if (!rst_n) return 9'b0;
    req = (m_waited > 0) || mem_read_m || mem_write_m;
    if (m_mem_stall()) return {5'b00000, 3'b001, req};
    if (ex_redirect)   return {5'b11111, 3'b110, req};
    if (m_load_use())  return {5'b00111, 3'b010, req};
    return {5'b11111, 3'b000, req};
  endfunction

  function automatic logic exp_pc();
    return rst_n && !m_mem_stall() && (ex_redirect || !m_load_use());
  endfunction

  // model state update
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_waited <= 0;
      m_err    <= 1'b0;
      m_cnt    <= '0;
    end else begin
      if (!exp_pc() && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
      if (m_waited == 0) begin
        if ((mem_read_m || mem_write_m) && !dmem_ready) m_waited <= 1;
      end else if (dmem_ready) begin
        m_waited <= 0;
      end else if (m_waited >= TMO) begin
        m_err    <= 1'b1;
        m_waited <= 0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    total = total + 1;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
         mem_wb_flush, dmem_req} !== exp_vec()) begin
      bad = bad + 1;
      $display("FAIL ctrl t=%0t actual=%b required=%b", $time,
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
                id_ex_flush, mem_wb_flush, dmem_req}, exp_vec());
    end
    total = total + 1;
    if (mem_err !== m_err) begin
      bad = bad + 1;
      $display("FAIL mem_err t=%0t actual=%b required=%b", $time, mem_err, m_err);
    end
    total = total + 1;
    if (stall_cnt !== m_cnt) begin
      bad = bad + 1;
      $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, m_cnt);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic set_in(input int rs, input int rt, input logic urt, input logic mr,
                        input logic wen, input int wa, input logic redir,
                        input logic mrm, input logic mwm, input logic rdy);
    id_rs = ASIZE'(rs); id_rt = ASIZE'(rt); id_uses_rt = urt;
    ex_mem_read = mr; ex_wen = wen; ex_waddr = ASIZE'(wa); ex_redirect = redir;
    mem_read_m = mrm; mem_write_m = mwm; dmem_ready = rdy;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic step(input int rs, input int rt, input logic urt, input logic mr,
                      input logic wen, input int wa, input logic redir,
                      input logic mrm, input logic mwm, input logic rdy);
    next();
    set_in(rs, rt, urt, mr, wen, wa, redir, mrm, mwm, rdy);
    settle();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // reset: outputs forced low even with a memory op pending
    mem_read_m = 1'b1;
    settle();
    check("rst_pc_en", pc_en, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_mem_wb_en", mem_wb_en, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    next(); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); settle();
    check("post_rst_pc_en", pc_en, 1);

    // load-use on $5
    step(5, 0, 0, 1, 1, 5, 0, 0, 0, 1);
    check("lu_pc_en", pc_en, 0);
    check("lu_if_id_en", if_id_en, 0);
    check("lu_id_ex_flush", id_ex_flush, 1);
    check("lu_ex_mem_en", ex_mem_en, 1);
    idle();
    check("lu_after_pc_en", pc_en, 1);
    check("lu_stall_cnt", stall_cnt, 1);

    // load to $0 never stalls
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    check("r0_pc_en", pc_en, 1);
    check("r0_id_ex_flush", id_ex_flush, 0);

    // three-cycle memory wait
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("mw_pc_en", pc_en, 0);
      check("mw_mem_wb_flush", mem_wb_flush, 1);
      check("mw_dmem_req", dmem_req, 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("mw_done_pc_en", pc_en, 1);
    check("mw_done_dmem_req", dmem_req, 1);
    idle();
    check("mw_stall_cnt", stall_cnt, 4);

    // redirect beats load-use
    step(7, 0, 0, 1, 1, 7, 1, 0, 0, 1);
    check("rd_pc_en", pc_en, 1);
    check("rd_if_id_flush", if_id_flush, 1);
    check("rd_id_ex_flush", id_ex_flush, 1);

    // redirect during a memory wait is held off until ready
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("rw_if_id_flush", if_id_flush, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("rw_pc_en", pc_en, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    check("rw_rel_if_id_flush", if_id_flush, 1);
    check("rw_rel_pc_en", pc_en, 1);

    // watchdog timeout
    for (int i = 0; i < TMO; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("to_pc_en", pc_en, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("to_rel_pc_en", pc_en, 1);
    check("to_rel_mem_err", mem_err, 0);
    idle();
    check("to_mem_err", mem_err, 1);
    repeat (3) idle();
    check("to_mem_err_sticky", mem_err, 1);

    // reset in the middle of a wait
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("mid_wait_req", dmem_req, 1);
    rst_n = 1'b0; #1;
    check("async_rst_req", dmem_req, 0);
    next(); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    check("rst_idle_req", dmem_req, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_cnt", stall_cnt, 0);

    // counter saturation
    for (int i = 0; i < 300; i++) step(0, 9, 1, 1, 1, 9, 0, 0, 0, 1);
    idle();
    check("sat_cnt", stall_cnt, 255);
    next(); rst_n = 1'b0; settle();
    next(); rst_n = 1'b1;

    // randomized traffic
    begin
      int rdy_pct = 5;
      for (int c = 0; c < 4000; c++) begin
        next();
        if (c % 200 == 0) rdy_pct = $urandom_range(0, 10);
        rst_n = ($urandom_range(0, 399) != 0);
        set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < rdy_pct));
      end
    end
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1);
  end

endmodule
